// File: rtl/xadac_pkg.sv
// Shared types for the xadac vector store path: ids, addresses, vector data,
// and the arbitrated AXI write id/request formats.
package xadac_pkg;

    localparam int IdWidth      = 4;
    localparam int AddrWidth    = 32;
    localparam int VecDataWidth = 32;
    localparam int VecStrbWidth = VecDataWidth / 8;

    localparam int DefNumMst  = 2;
    localparam int DefMstIdxW = $clog2(DefNumMst);

    typedef logic [IdWidth-1:0]      IdT;
    typedef logic [AddrWidth-1:0]    AddrT;
    typedef logic [VecDataWidth-1:0] VecDataT;
    typedef logic [VecStrbWidth-1:0] VecStrbT;

    // Downstream id: master index prepended to the master's own id.
    typedef logic [DefMstIdxW+IdWidth-1:0] ArbIdT;

    typedef struct packed {
        IdT   id;
        AddrT addr;
    } AwReqT;

endpackage

// File: rtl/xadac_fifo.sv
// Synchronous FIFO with a combinational head; a push is refused while full
// even if a pop happens in the same cycle.
module xadac_fifo #(
    parameter int  Depth = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PtrW = $clog2(Depth);

    T                mem [Depth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [PtrW:0]   count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_reg == (PtrW+1)'(Depth));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/xadac_axi_wr_arb.sv
// Round-robin arbiter sharing one AXI write port between NumMst store units;
// W beats follow AW grant order and B responses route back by the id prefix.
module xadac_axi_wr_arb
    import xadac_pkg::*;
#(
    parameter int NumMst     = 2,
    parameter int WFifoDepth = 4,
    parameter int MstIdxW    = $clog2(NumMst)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NumMst-1:0][IdWidth-1:0]    mst_aw_id,
    input  logic [NumMst-1:0][AddrWidth-1:0]  mst_aw_addr,
    input  logic [NumMst-1:0]                 mst_aw_valid,
    output logic [NumMst-1:0]                 mst_aw_ready,
    input  logic [NumMst-1:0][VecDataWidth-1:0] mst_w_data,
    input  logic [NumMst-1:0][VecStrbWidth-1:0] mst_w_strb,
    input  logic [NumMst-1:0]                 mst_w_valid,
    output logic [NumMst-1:0]                 mst_w_ready,
    output logic [IdWidth-1:0]                mst_b_id,
    output logic [NumMst-1:0]                 mst_b_valid,
    input  logic [NumMst-1:0]                 mst_b_ready,
    output logic [MstIdxW+IdWidth-1:0]        axi_aw_id,
    output logic [AddrWidth-1:0]              axi_aw_addr,
    output logic                              axi_aw_valid,
    input  logic                              axi_aw_ready,
    output logic [VecDataWidth-1:0]           axi_w_data,
    output logic [VecStrbWidth-1:0]           axi_w_strb,
    output logic                              axi_w_valid,
    input  logic                              axi_w_ready,
    input  logic [MstIdxW+IdWidth-1:0]        axi_b_id,
    input  logic                              axi_b_valid,
    output logic                              axi_b_ready
);

    logic [MstIdxW-1:0] rr_ptr_reg;
    logic [MstIdxW-1:0] grant_idx;
    logic [MstIdxW-1:0] lo_idx;
    logic [MstIdxW-1:0] hi_idx;
    logic               lo_found;
    logic               hi_found;
    logic               grant_found;
    logic               aw_free;
    logic               aw_hs;
    AwReqT              aw_req_reg;
    logic [MstIdxW-1:0] aw_idx_reg;

    logic               fifo_full;
    logic               fifo_empty;
    logic [MstIdxW-1:0] fifo_head;
    logic               w_free;
    logic               w_pop;

    logic [MstIdxW-1:0] b_idx;
    logic               b_ready_sel;

    // ---------------- AW arbitration ----------------
    // Lowest valid master at/after rr_ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int j = NumMst - 1; j >= 0; j--) begin
            if (mst_aw_valid[j]) begin
                lo_found = 1'b1;
                lo_idx   = MstIdxW'(j);
                if (MstIdxW'(j) >= rr_ptr_reg) begin
                    hi_found = 1'b1;
                    hi_idx   = MstIdxW'(j);
                end
            end
        end
        grant_found = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign aw_free = !axi_aw_valid || axi_aw_ready;
    assign aw_hs   = aw_free && !fifo_full && grant_found && !rst;

    always_comb begin
        mst_aw_ready = '0;
        for (int j = 0; j < NumMst; j++) begin
            if (grant_idx == MstIdxW'(j)) mst_aw_ready[j] = aw_hs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg   <= '0;
            axi_aw_valid <= 1'b0;
            aw_req_reg   <= '0;
            aw_idx_reg   <= '0;
        end else if (aw_hs) begin
            rr_ptr_reg      <= (grant_idx == MstIdxW'(NumMst - 1)) ? '0 : grant_idx + 1'b1;
            axi_aw_valid    <= 1'b1;
            aw_idx_reg      <= grant_idx;
            aw_req_reg.id   <= mst_aw_id[grant_idx];
            aw_req_reg.addr <= mst_aw_addr[grant_idx];
        end else if (axi_aw_ready) begin
            axi_aw_valid <= 1'b0;
        end
    end

    assign axi_aw_id   = {aw_idx_reg, aw_req_reg.id};
    assign axi_aw_addr = aw_req_reg.addr;

    // ---------------- grant-order FIFO ----------------
    xadac_fifo #(
        .Depth (WFifoDepth),
        .T     (logic [MstIdxW-1:0])
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (aw_hs),
        .din   (grant_idx),
        .pop   (w_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // ---------------- W forwarding ----------------
    assign w_free = !axi_w_valid || axi_w_ready;

    always_comb begin
        mst_w_ready = '0;
        w_pop       = 1'b0;
        for (int j = 0; j < NumMst; j++) begin
            if (fifo_head == MstIdxW'(j)) begin
                mst_w_ready[j] = w_free && !fifo_empty && !rst;
                w_pop          = w_free && !fifo_empty && !rst && mst_w_valid[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axi_w_valid <= 1'b0;
            axi_w_data  <= '0;
            axi_w_strb  <= '0;
        end else if (w_pop) begin
            axi_w_valid <= 1'b1;
            axi_w_data  <= mst_w_data[fifo_head];
            axi_w_strb  <= mst_w_strb[fifo_head];
        end else if (axi_w_ready) begin
            axi_w_valid <= 1'b0;
        end
    end

    // ---------------- B routing ----------------
    // Index values with no master behind them are acknowledged and dropped.
    assign b_idx    = axi_b_id[MstIdxW+IdWidth-1 -: MstIdxW];
    assign mst_b_id = axi_b_id[IdWidth-1:0];

    always_comb begin
        mst_b_valid = '0;
        b_ready_sel = 1'b1;
        for (int j = 0; j < NumMst; j++) begin
            if (b_idx == MstIdxW'(j)) begin
                mst_b_valid[j] = axi_b_valid && !rst;
                b_ready_sel    = mst_b_ready[j];
            end
        end
    end

    assign axi_b_ready = b_ready_sel && !rst;

endmodule

// File: tb/tb_xadac_axi_wr_arb.sv
// Directed bench for xadac_axi_wr_arb: one task per scenario, inline checks.
module tb_xadac_axi_wr_arb;
    import xadac_pkg::*;

    logic                            clk;
    logic                            rst;
    logic [1:0][IdWidth-1:0]         mst_aw_id;
    logic [1:0][AddrWidth-1:0]       mst_aw_addr;
    logic [1:0]                      mst_aw_valid;
    logic [1:0]                      mst_aw_ready;
    logic [1:0][VecDataWidth-1:0]    mst_w_data;
    logic [1:0][VecStrbWidth-1:0]    mst_w_strb;
    logic [1:0]                      mst_w_valid;
    logic [1:0]                      mst_w_ready;
    logic [IdWidth-1:0]              mst_b_id;
    logic [1:0]                      mst_b_valid;
    logic [1:0]                      mst_b_ready;
    logic [IdWidth:0]                axi_aw_id;
    logic [AddrWidth-1:0]            axi_aw_addr;
    logic                            axi_aw_valid;
    logic                            axi_aw_ready;
    logic [VecDataWidth-1:0]         axi_w_data;
    logic [VecStrbWidth-1:0]         axi_w_strb;
    logic                            axi_w_valid;
    logic                            axi_w_ready;
    logic [IdWidth:0]                axi_b_id;
    logic                            axi_b_valid;
    logic                            axi_b_ready;

    int checks;
    int failures;

    xadac_axi_wr_arb #(.NumMst(2), .WFifoDepth(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mst_aw_id    (mst_aw_id),
        .mst_aw_addr  (mst_aw_addr),
        .mst_aw_valid (mst_aw_valid),
        .mst_aw_ready (mst_aw_ready),
        .mst_w_data   (mst_w_data),
        .mst_w_strb   (mst_w_strb),
        .mst_w_valid  (mst_w_valid),
        .mst_w_ready  (mst_w_ready),
        .mst_b_id     (mst_b_id),
        .mst_b_valid  (mst_b_valid),
        .mst_b_ready  (mst_b_ready),
        .axi_aw_id    (axi_aw_id),
        .axi_aw_addr  (axi_aw_addr),
        .axi_aw_valid (axi_aw_valid),
        .axi_aw_ready (axi_aw_ready),
        .axi_w_data   (axi_w_data),
        .axi_w_strb   (axi_w_strb),
        .axi_w_valid  (axi_w_valid),
        .axi_w_ready  (axi_w_ready),
        .axi_b_id     (axi_b_id),
        .axi_b_valid  (axi_b_valid),
        .axi_b_ready  (axi_b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mst_aw_id    = '0;
        mst_aw_addr  = '0;
        mst_aw_valid = '0;
        mst_w_data   = '0;
        mst_w_strb   = '0;
        mst_w_valid  = '0;
        mst_b_ready  = '0;
        axi_aw_ready = 1'b0;
        axi_w_ready  = 1'b0;
        axi_b_id     = '0;
        axi_b_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mst_aw_valid = 2'b11;
        tick();
        checks++;
        if ({axi_aw_valid, axi_w_valid, axi_b_ready, mst_aw_ready, mst_w_ready, mst_b_valid} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {axi_aw_valid, axi_w_valid, axi_b_ready, mst_aw_ready, mst_w_ready, mst_b_valid});
        end
        checks++;
        if ({axi_aw_id, axi_aw_addr, axi_w_data, axi_w_strb} !== '0) begin
            failures++;
            $display("FAIL reset_payload got id=%h addr=%h data=%h strb=%h exp=0",
                     axi_aw_id, axi_aw_addr, axi_w_data, axi_w_strb);
        end
        rst = 1'b0;
        clear_inputs();
        #1;
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        do_reset();
        axi_aw_ready   = 1'b1;
        axi_w_ready    = 1'b1;
        mst_aw_id[0]   = 4'd3;
        mst_aw_addr[0] = 32'h100;
        mst_aw_valid   = 2'b01;
        #1;
        checks++;
        if (mst_aw_ready !== 2'b01) begin
            failures++; $display("FAIL single_aw_ready got=%b exp=01", mst_aw_ready);
        end
        tick();
        mst_aw_valid = 2'b00;
        checks++;
        if (axi_aw_valid !== 1'b1 || axi_aw_id !== 5'h03 || axi_aw_addr !== 32'h100) begin
            failures++;
            $display("FAIL single_aw_out got v=%b id=%h addr=%h exp v=1 id=03 addr=100",
                     axi_aw_valid, axi_aw_id, axi_aw_addr);
        end
        mst_w_data[0] = 32'hA5;
        mst_w_strb[0] = 4'hF;
        mst_w_valid   = 2'b01;
        #1;
        checks++;
        if (mst_w_ready !== 2'b01) begin
            failures++; $display("FAIL single_w_ready got=%b exp=01", mst_w_ready);
        end
        tick();
        mst_w_valid = 2'b00;
        checks++;
        if (axi_w_valid !== 1'b1 || axi_w_data !== 32'hA5 || axi_w_strb !== 4'hF || axi_aw_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_w_out got wv=%b data=%h strb=%h awv=%b exp wv=1 data=a5 strb=f awv=0",
                     axi_w_valid, axi_w_data, axi_w_strb, axi_aw_valid);
        end
        tick();
        axi_b_id    = 5'h03;
        axi_b_valid = 1'b1;
        mst_b_ready = 2'b01;
        #1;
        checks++;
        if (mst_b_valid !== 2'b01 || mst_b_id !== 4'd3 || axi_b_ready !== 1'b1 || axi_w_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_b got bv=%b bid=%0d bready=%b wv=%b exp bv=01 bid=3 bready=1 wv=0",
                     mst_b_valid, mst_b_id, axi_b_ready, axi_w_valid);
        end
        axi_b_valid = 1'b0;
        $display("test_single_write done");
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        do_reset();
        axi_aw_ready   = 1'b1;
        axi_w_ready    = 1'b1;
        mst_aw_id[0]   = 4'd1;
        mst_aw_id[1]   = 4'd2;
        mst_aw_addr[0] = 32'h1000;
        mst_aw_addr[1] = 32'h2000;
        mst_aw_valid   = 2'b11;
        mst_w_valid    = 2'b11;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (mst_aw_ready !== exp_rdy) begin
                failures++; $display("FAIL contention_ready[%0d] got=%b exp=%b", i, mst_aw_ready, exp_rdy);
            end
            tick();
            checks++;
            if (axi_aw_valid !== 1'b1 || axi_aw_id[IdWidth] !== 1'(i % 2) ||
                axi_aw_addr !== ((i % 2 == 0) ? 32'h1000 : 32'h2000)) begin
                failures++;
                $display("FAIL contention_aw[%0d] got v=%b id=%h addr=%h exp idx=%0d",
                         i, axi_aw_valid, axi_aw_id, axi_aw_addr, i % 2);
            end
        end
        clear_inputs();
        $display("test_contention done");
    endtask

    task automatic test_order();
        do_reset();
        axi_aw_ready  = 1'b1;
        axi_w_ready   = 1'b1;
        mst_aw_id[1]  = 4'd4;
        mst_aw_valid  = 2'b10;
        tick();
        mst_aw_id[0]  = 4'd5;
        mst_aw_valid  = 2'b01;
        mst_w_data[0] = 32'hC0;
        mst_w_valid   = 2'b01;
        #1;
        checks++;
        if (mst_w_ready !== 2'b10) begin
            failures++; $display("FAIL order_head_m1 got=%b exp=10", mst_w_ready);
        end
        tick();
        mst_aw_valid = 2'b00;
        checks++;
        if (mst_w_ready !== 2'b10 || axi_w_valid !== 1'b0) begin
            failures++; $display("FAIL order_m0_blocked got rdy=%b wv=%b exp rdy=10 wv=0", mst_w_ready, axi_w_valid);
        end
        mst_w_data[1] = 32'hB1;
        mst_w_valid   = 2'b11;
        tick();
        mst_w_valid = 2'b01;
        checks++;
        if (axi_w_valid !== 1'b1 || axi_w_data !== 32'hB1 || mst_w_ready !== 2'b01) begin
            failures++;
            $display("FAIL order_first_w got v=%b data=%h rdy=%b exp v=1 data=b1 rdy=01",
                     axi_w_valid, axi_w_data, mst_w_ready);
        end
        tick();
        mst_w_valid = 2'b00;
        checks++;
        if (axi_w_valid !== 1'b1 || axi_w_data !== 32'hC0) begin
            failures++; $display("FAIL order_second_w got v=%b data=%h exp v=1 data=c0", axi_w_valid, axi_w_data);
        end
        clear_inputs();
        $display("test_order done");
    endtask

    task automatic test_fifo_full();
        do_reset();
        axi_aw_ready = 1'b1;
        axi_w_ready  = 1'b0;
        mst_aw_valid = 2'b01;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mst_aw_ready !== 2'b01) begin
                failures++; $display("FAIL full_fill[%0d] got=%b exp=01", i, mst_aw_ready);
            end
            tick();
        end
        checks++;
        if (mst_aw_ready !== 2'b00) begin
            failures++; $display("FAIL full_stall got=%b exp=00", mst_aw_ready);
        end
        tick();
        mst_w_data[0] = 32'hD0;
        mst_w_valid   = 2'b01;
        #1;
        checks++;
        if (mst_w_ready !== 2'b01 || mst_aw_ready !== 2'b00) begin
            failures++;
            $display("FAIL full_pop_no_push got wrdy=%b awrdy=%b exp wrdy=01 awrdy=00", mst_w_ready, mst_aw_ready);
        end
        tick();
        mst_w_valid = 2'b00;
        checks++;
        if (mst_aw_ready !== 2'b01 || axi_w_valid !== 1'b1 || mst_w_ready !== 2'b00) begin
            failures++;
            $display("FAIL full_resume got awrdy=%b wv=%b wrdy=%b exp awrdy=01 wv=1 wrdy=00",
                     mst_aw_ready, axi_w_valid, mst_w_ready);
        end
        tick();
        checks++;
        if (mst_aw_ready !== 2'b00) begin
            failures++; $display("FAIL full_refill got=%b exp=00", mst_aw_ready);
        end
        clear_inputs();
        $display("test_fifo_full done");
    endtask

    task automatic test_aw_stall();
        do_reset();
        axi_aw_ready   = 1'b0;
        mst_aw_id[0]   = 4'd5;
        mst_aw_addr[0] = 32'h200;
        mst_aw_valid   = 2'b01;
        tick();
        mst_aw_id[0]   = 4'd6;
        mst_aw_addr[0] = 32'h300;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (axi_aw_valid !== 1'b1 || axi_aw_id !== 5'h05 || axi_aw_addr !== 32'h200 || mst_aw_ready !== 2'b00) begin
                failures++;
                $display("FAIL stall_hold[%0d] got v=%b id=%h addr=%h rdy=%b exp v=1 id=05 addr=200 rdy=00",
                         i, axi_aw_valid, axi_aw_id, axi_aw_addr, mst_aw_ready);
            end
            tick();
        end
        axi_aw_ready = 1'b1;
        #1;
        checks++;
        if (mst_aw_ready !== 2'b01) begin
            failures++; $display("FAIL stall_release_ready got=%b exp=01", mst_aw_ready);
        end
        tick();
        mst_aw_valid = 2'b00;
        checks++;
        if (axi_aw_valid !== 1'b1 || axi_aw_id !== 5'h06 || axi_aw_addr !== 32'h300) begin
            failures++;
            $display("FAIL stall_next got v=%b id=%h addr=%h exp v=1 id=06 addr=300", axi_aw_valid, axi_aw_id, axi_aw_addr);
        end
        clear_inputs();
        $display("test_aw_stall done");
    endtask

    task automatic test_b_route_and_reset();
        do_reset();
        axi_b_id    = 5'h17;
        axi_b_valid = 1'b1;
        mst_b_ready = 2'b10;
        #1;
        checks++;
        if (mst_b_valid !== 2'b10 || mst_b_id !== 4'd7 || axi_b_ready !== 1'b1) begin
            failures++;
            $display("FAIL b_route_m1 got bv=%b id=%0d rdy=%b exp bv=10 id=7 rdy=1", mst_b_valid, mst_b_id, axi_b_ready);
        end
        mst_b_ready = 2'b01;
        #1;
        checks++;
        if (axi_b_ready !== 1'b0) begin
            failures++; $display("FAIL b_ready_sel got=%b exp=0", axi_b_ready);
        end
        axi_b_id = 5'h02;
        #1;
        checks++;
        if (mst_b_valid !== 2'b01 || mst_b_id !== 4'd2 || axi_b_ready !== 1'b1) begin
            failures++;
            $display("FAIL b_route_m0 got bv=%b id=%0d rdy=%b exp bv=01 id=2 rdy=1", mst_b_valid, mst_b_id, axi_b_ready);
        end
        axi_aw_ready = 1'b1;
        mst_aw_valid = 2'b11;
        tick();
        tick();
        mst_aw_valid = 2'b00;
        mst_w_valid  = 2'b11;
        rst          = 1'b1;
        tick();
        checks++;
        if (axi_aw_valid !== 1'b0 || axi_w_valid !== 1'b0 || mst_b_valid !== 2'b00 ||
            mst_w_ready !== 2'b00 || mst_aw_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid got awv=%b wv=%b bv=%b wrdy=%b awrdy=%b exp all 0",
                     axi_aw_valid, axi_w_valid, mst_b_valid, mst_w_ready, mst_aw_ready);
        end
        rst         = 1'b0;
        axi_w_ready = 1'b1;
        #1;
        checks++;
        if (mst_w_ready !== 2'b00 || axi_aw_valid !== 1'b0) begin
            failures++; $display("FAIL reset_fifo_empty got wrdy=%b awv=%b exp wrdy=00 awv=0", mst_w_ready, axi_aw_valid);
        end
        clear_inputs();
        $display("test_b_route_and_reset done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_contention();
        test_order();
        test_fifo_full();
        test_aw_stall();
        test_b_route_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
